// File: rtl/loteria_multi.sv
// Multi-player lottery grader: holds a K-number draw, grades one ticket per
// player per round, and keeps a saturating score for each player.
module loteria_multi #(
    parameter int W       = 4,
    parameter int K       = 4,
    parameter int N_JOG   = 2,
    parameter int SCORE_W = 5,
    parameter int RUN_MIN = 3,
    parameter int BONUS   = 2
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [W-1:0]                                 numero,
    input  logic                                         insere,
    input  logic                                         fim,
    input  logic                                         fim_jogo,
    output logic [1:0]                                   premio,
    output logic [$clog2(K+1)-1:0]                       acertos,
    output logic [((N_JOG > 1) ? $clog2(N_JOG) : 1)-1:0] jogador,
    output logic                                         valido,
    output logic [N_JOG*SCORE_W-1:0]                     pontos,
    output logic                                         encerrado
);

    localparam int CW   = $clog2(K + 1);
    localparam int JW   = (N_JOG > 1) ? $clog2(N_JOG) : 1;
    localparam int IW   = $clog2(K);
    localparam int SMAX = (1 << SCORE_W) - 1;

    typedef enum logic [2:0] {
        SORTEIO,
        APOSTA,
        AVALIA,
        RODADA,
        FIM
    } state_t;

    state_t                   state_q, state_d;
    logic [W-1:0]             draw_q [K];
    logic [W-1:0]             draw_d [K];
    logic [CW-1:0]            pos_q, pos_d;
    logic [CW-1:0]            hits_q, hits_d;
    logic [CW-1:0]            run_q, run_d;
    logic [CW-1:0]            best_q, best_d;
    logic [CW-1:0]            acertos_q, acertos_d;
    logic [JW-1:0]            jog_q, jog_d;
    logic [1:0]               premio_q, premio_d;
    logic                     valido_q, valido_d;
    logic [N_JOG*SCORE_W-1:0] pontos_q, pontos_d;

    logic [IW-1:0]      idx;
    logic [CW-1:0]      run_inc;
    logic               run_ok;
    logic [SCORE_W-1:0] cur;
    logic [31:0]        sum;

    // pos stays below K whenever the draw is indexed
    assign idx     = pos_q[IW-1:0];
    assign run_inc = run_q + CW'(1);
    assign run_ok  = best_q >= CW'(RUN_MIN);
    assign cur     = pontos_q[int'(jog_q)*SCORE_W +: SCORE_W];
    assign sum     = 32'(cur) + 32'(hits_q) + (run_ok ? 32'(BONUS) : 32'd0);

    // Next-state, ticket grading and score update
    always_comb begin
        state_d   = state_q;
        draw_d    = draw_q;
        pos_d     = pos_q;
        hits_d    = hits_q;
        run_d     = run_q;
        best_d    = best_q;
        acertos_d = acertos_q;
        jog_d     = jog_q;
        premio_d  = premio_q;
        valido_d  = 1'b0;
        pontos_d  = pontos_q;
        if (fim_jogo && state_q != FIM) begin
            state_d = FIM;
        end else begin
            unique case (state_q)
                SORTEIO: begin
                    if (insere) begin
                        draw_d[idx] = numero;
                        if (pos_q == CW'(K - 1)) begin
                            pos_d   = '0;
                            jog_d   = '0;
                            state_d = APOSTA;
                        end else begin
                            pos_d = pos_q + CW'(1);
                        end
                    end
                end
                APOSTA: begin
                    if (insere) begin
                        pos_d = pos_q + CW'(1);
                        if (numero == draw_q[idx]) begin
                            hits_d = hits_q + CW'(1);
                            run_d  = run_inc;
                            if (run_inc > best_q) best_d = run_inc;
                        end else begin
                            run_d = '0;
                        end
                    end
                    if (fim || (insere && pos_q == CW'(K - 1))) begin
                        state_d = AVALIA;
                    end
                end
                AVALIA: begin
                    acertos_d = hits_q;
                    if (hits_q == CW'(K))          premio_d = 2'b10;
                    else if (run_ok)               premio_d = 2'b11;
                    else if (hits_q >= CW'(K / 2)) premio_d = 2'b01;
                    else                           premio_d = 2'b00;
                    pontos_d[int'(jog_q)*SCORE_W +: SCORE_W] =
                        (sum > 32'(SMAX)) ? SCORE_W'(SMAX) : sum[SCORE_W-1:0];
                    valido_d = 1'b1;
                    hits_d   = '0;
                    run_d    = '0;
                    best_d   = '0;
                    pos_d    = '0;
                    if (jog_q < JW'(N_JOG - 1)) begin
                        jog_d   = jog_q + JW'(1);
                        state_d = APOSTA;
                    end else begin
                        state_d = RODADA;
                    end
                end
                RODADA: begin
                    if (insere) begin
                        draw_d[0] = numero;
                        pos_d     = CW'(1);
                        jog_d     = '0;
                        state_d   = SORTEIO;
                    end
                end
                FIM: begin
                    state_d = FIM;
                end
                default: begin
                    state_d = SORTEIO;
                end
            endcase
        end
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= SORTEIO;
            draw_q    <= '{default: '0};
            pos_q     <= '0;
            hits_q    <= '0;
            run_q     <= '0;
            best_q    <= '0;
            acertos_q <= '0;
            jog_q     <= '0;
            premio_q  <= '0;
            valido_q  <= 1'b0;
            pontos_q  <= '0;
        end else begin
            state_q   <= state_d;
            draw_q    <= draw_d;
            pos_q     <= pos_d;
            hits_q    <= hits_d;
            run_q     <= run_d;
            best_q    <= best_d;
            acertos_q <= acertos_d;
            jog_q     <= jog_d;
            premio_q  <= premio_d;
            valido_q  <= valido_d;
            pontos_q  <= pontos_d;
        end
    end

    assign premio    = premio_q;
    assign acertos   = acertos_q;
    assign jogador   = jog_q;
    assign valido    = valido_q;
    assign pontos    = pontos_q;
    assign encerrado = (state_q == FIM);

endmodule

// File: tb/tb_loteria_multi.sv
// Directed bench for loteria_multi with default parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_loteria_multi;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] numero = '0;
    logic       insere = 1'b0;
    logic       fim = 1'b0;
    logic       fim_jogo = 1'b0;
    logic [1:0] premio;
    logic [2:0] acertos;
    logic [0:0] jogador;
    logic       valido;
    logic [9:0] pontos;
    logic       encerrado;

    int checks = 0;
    int failures = 0;

    loteria_multi dut (
        .clock    (clock),
        .reset    (reset),
        .numero   (numero),
        .insere   (insere),
        .fim      (fim),
        .fim_jogo (fim_jogo),
        .premio   (premio),
        .acertos  (acertos),
        .jogador  (jogador),
        .valido   (valido),
        .pontos   (pontos),
        .encerrado(encerrado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic ins(input logic [3:0] n);
        @(negedge clock);
        numero = n;
        insere = 1'b1;
        @(negedge clock);
        insere = 1'b0;
    endtask

    task automatic ins_fim(input logic [3:0] n);
        @(negedge clock);
        numero = n;
        insere = 1'b1;
        fim    = 1'b1;
        @(negedge clock);
        insere = 1'b0;
        fim    = 1'b0;
    endtask

    task automatic do_fim();
        @(negedge clock);
        fim = 1'b1;
        @(negedge clock);
        fim = 1'b0;
    endtask

    task automatic four(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        ins(a);
        ins(b);
        ins(c);
        ins(d);
    endtask

    // Called right after the closing input of a ticket
    task automatic result(input string tag, input int acc, input int pre,
                          input int p0, input int p1, input int jog);
        @(negedge clock);
        chk({tag, "_valido"}, 32'(valido), 1);
        chk({tag, "_acertos"}, 32'(acertos), acc);
        chk({tag, "_premio"}, 32'(premio), pre);
        chk({tag, "_pontos0"}, 32'(pontos[4:0]), p0);
        chk({tag, "_pontos1"}, 32'(pontos[9:5]), p1);
        chk({tag, "_jogador"}, 32'(jogador), jog);
        @(negedge clock);
        chk({tag, "_valido_drop"}, 32'(valido), 0);
    endtask

    initial begin
        #1;
        chk("rst_pontos", 32'(pontos), 0);
        chk("rst_valido", 32'(valido), 0);
        chk("rst_encerrado", 32'(encerrado), 0);
        chk("rst_premio", 32'(premio), 0);
        chk("rst_acertos", 32'(acertos), 0);
        @(negedge clock);
        reset = 1'b1;

        // Round 1: full hit for P0, three hits (run 2) for P1
        four(3, 8, 2, 0);
        four(3, 8, 2, 0);
        result("r1_p0", 4, 2, 6, 0, 1);
        four(3, 8, 1, 0);
        result("r1_p1", 3, 1, 6, 3, 1);
        repeat (3) @(negedge clock);
        chk("rodada_hold_premio", 32'(premio), 1);
        chk("rodada_hold_pontos1", 32'(pontos[9:5]), 3);

        // Round 2: early close with fim, and insere+fim together
        four(3, 8, 2, 0);
        chk("r2_jogador0", 32'(jogador), 0);
        ins(3);
        ins(8);
        do_fim();
        result("r2_p0_fim", 2, 1, 8, 3, 1);
        ins(3);
        ins_fim(8);
        result("r2_p1_insfim", 2, 1, 8, 5, 1);

        // Round 3: run prize for P1
        four(3, 8, 2, 0);
        four(3, 8, 2, 0);
        result("r3_p0", 4, 2, 14, 5, 1);
        four(3, 8, 2, 9);
        result("r3_p1_run", 3, 3, 14, 10, 1);

        // Rounds 4..7: P0 score climbs 20, 26, then saturates at 31
        for (int r = 0; r < 4; r++) begin
            int exp0;
            exp0 = 14 + 6 * (r + 1);
            if (exp0 > 31) exp0 = 31;
            four(3, 8, 2, 0);
            four(3, 8, 2, 0);
            result($sformatf("sat%0d_p0", r), 4, 2, exp0, 10, 1);
            four(1, 1, 1, 1);
            result($sformatf("sat%0d_p1", r), 0, 0, exp0, 10, 1);
        end

        // End of game mid-ticket: nothing graded, inputs ignored
        four(3, 8, 2, 0);
        ins(3);
        ins(8);
        @(negedge clock);
        fim_jogo = 1'b1;
        @(negedge clock);
        fim_jogo = 1'b0;
        chk("fj_encerrado", 32'(encerrado), 1);
        chk("fj_valido", 32'(valido), 0);
        ins(2);
        ins(0);
        repeat (2) begin
            @(negedge clock);
            chk("fj_no_valido", 32'(valido), 0);
        end
        four(3, 3, 3, 3);
        chk("fj_encerrado_hold", 32'(encerrado), 1);
        chk("fj_pontos0", 32'(pontos[4:0]), 31);
        chk("fj_pontos1", 32'(pontos[9:5]), 10);
        chk("fj_premio", 32'(premio), 0);

        // Reset leaves FIM; new game then reset again mid-APOSTA
        #2;
        reset = 1'b0;
        #1;
        chk("rst2_encerrado", 32'(encerrado), 0);
        chk("rst2_pontos", 32'(pontos), 0);
        @(negedge clock);
        reset = 1'b1;
        four(1, 2, 3, 4);
        four(1, 2, 3, 4);
        result("g2_p0", 4, 2, 6, 0, 1);
        ins(1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst3_pontos", 32'(pontos), 0);
        chk("rst3_valido", 32'(valido), 0);
        chk("rst3_encerrado", 32'(encerrado), 0);
        chk("rst3_jogador", 32'(jogador), 0);
        chk("rst3_acertos", 32'(acertos), 0);
        @(negedge clock);
        reset = 1'b1;

        // Back in SORTEIO: fresh draw, hits 3 with best run 2
        four(5, 5, 5, 5);
        four(5, 6, 5, 5);
        result("g3_p0", 3, 1, 3, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
